// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace packet sequencer slice.
package trdb_pkg;

    localparam int unsigned TRDB_WORD_W    = 32;
    localparam int unsigned TRDB_MAX_WORDS = 4;

    typedef logic [TRDB_MAX_WORDS*TRDB_WORD_W-1:0] packet_t;

    typedef struct packed {
        packet_t    bits;
        logic [2:0] words;
    } trdb_packet_entry_t;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_SEND
    } trdb_seq_state_e;

endpackage

// File: rtl/trdb_packet_fifo.sv
// Synchronous packet FIFO with flush; level is an explicit 0..DEPTH counter.
module trdb_packet_fifo #(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = logic [7:0]
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           push_i,
    input  entry_t                         data_i,
    input  logic                           pop_i,
    output entry_t                         head_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q;
    logic               do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_q <= level_q + 1'b1;
            else if (do_pop && !do_push) level_q <= level_q - 1'b1;
        end
    end

endmodule

// File: rtl/trdb_packet_sequencer.sv
// Queues 1..4-word trace packets and streams them word-by-word with a last marker;
// no input backpressure, so overflowing or malformed packets are dropped and counted.
module trdb_packet_sequencer
    import trdb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned PACKET_TOTAL = 128,
    parameter int unsigned WORD_W       = 32,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              enable_i,
    input  logic                              flush_i,
    input  logic [PACKET_TOTAL-1:0]           packet_i,
    input  logic [2:0]                        packet_words_i,
    input  logic                              packet_valid_i,
    output logic [WORD_W-1:0]                 word_o,
    output logic                              word_valid_o,
    output logic                              word_last_o,
    input  logic                              word_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
    output logic                              overflow_o,
    output logic [CNT_W-1:0]                  drop_cnt_o
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH+1);

    trdb_seq_state_e    state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               overflow_q, overflow_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

    trdb_packet_entry_t head, wr_entry;
    logic               fifo_full, fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    logic               len_ok, attempt, push, drop, fire, is_last, pop;

    assign len_ok   = (packet_words_i != 3'd0) && (packet_words_i <= 3'(TRDB_MAX_WORDS));
    assign attempt  = packet_valid_i && enable_i && !flush_i;
    assign push     = attempt && len_ok && !fifo_full;
    assign drop     = attempt && (!len_ok || fifo_full);

    assign word_valid_o = (state_q == SEQ_SEND) && !fifo_empty;
    assign is_last      = ({1'b0, idx_q} == (head.words - 3'd1));
    assign fire         = word_valid_o && word_ready_i;
    assign pop          = fire && is_last;

    assign wr_entry = '{bits: packet_t'(packet_i), words: packet_words_i};

    trdb_packet_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (trdb_packet_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (push),
        .data_i  (wr_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    // Leaving IDLE on the push itself (not on level>0) gives one-cycle latency.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            SEQ_IDLE: begin
                if (push) state_d = SEQ_SEND;
            end
            SEQ_SEND: begin
                if (fire) begin
                    if (is_last) begin
                        idx_d = '0;
                        if (!((fifo_level > LVL_W'(1)) || push)) state_d = SEQ_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
        if (flush_i) begin
            state_d = SEQ_IDLE;
            idx_d   = '0;
        end
    end

    always_comb begin
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
        if (flush_i) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= SEQ_IDLE;
            idx_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign word_o       = word_valid_o ? head.bits[idx_q*WORD_W +: WORD_W] : '0;
    assign word_last_o  = word_valid_o && is_last;
    assign fifo_level_o = fifo_level;
    assign overflow_o   = overflow_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_trdb_packet_sequencer.sv
// Directed self-checking bench for trdb_packet_sequencer.
module tb_trdb_packet_sequencer;

    logic          clk = 1'b0;
    logic          rst_i, enable_i, flush_i, packet_valid_i, word_ready_i;
    logic [127:0]  packet_i;
    logic [2:0]    packet_words_i;
    logic [31:0]   word_o;
    logic          word_valid_o, word_last_o, overflow_o;
    logic [2:0]    fifo_level_o;
    logic [15:0]   drop_cnt_o;

    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;

    always #5 clk = ~clk;

    trdb_packet_sequencer #(
        .FIFO_DEPTH   (4),
        .PACKET_TOTAL (128),
        .WORD_W       (32),
        .CNT_W        (16)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .flush_i        (flush_i),
        .packet_i       (packet_i),
        .packet_words_i (packet_words_i),
        .packet_valid_i (packet_valid_i),
        .word_o         (word_o),
        .word_valid_o   (word_valid_o),
        .word_last_o    (word_last_o),
        .word_ready_i   (word_ready_i),
        .fifo_level_o   (fifo_level_o),
        .overflow_o     (overflow_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        packet_valid_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; enable_i = 1'b1; flush_i = 1'b0; packet_valid_i = 1'b0;
        word_ready_i = 1'b0; packet_i = '0; packet_words_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", word_valid_o); end
        n_checks++; if (word_o !== 32'h0) begin n_fail++; $display("FAIL reset_word: got %h expected 0", word_o); end
        n_checks++; if (word_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", word_last_o); end
        n_checks++; if (fifo_level_o !== 3'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", fifo_level_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow_o); end
        n_checks++; if (drop_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_drop_cnt: got %h expected 0", drop_cnt_o); end
    endtask

    task automatic test_single();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'hAAAAAAAA; exp_w[1] = 32'hBBBBBBBB; exp_w[2] = 32'hCCCCCCCC;
        word_ready_i = 1'b1;
        packet_i = {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
        packet_words_i = 3'd3; packet_valid_i = 1'b1;
        tick();
        packet_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (word_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %b expected 1", i, word_valid_o); end
            n_checks++; if (word_o !== exp_w[i]) begin n_fail++; $display("FAIL single_word[%0d]: got %h expected %h", i, word_o, exp_w[i]); end
            n_checks++; if (word_last_o !== (i == 2)) begin n_fail++; $display("FAIL single_last[%0d]: got %b expected %b", i, word_last_o, (i == 2)); end
            n_checks++; if (fifo_level_o !== 3'd1) begin n_fail++; $display("FAIL single_level[%0d]: got %0d expected 1", i, fifo_level_o); end
            tick();
        end
        n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_end_valid: got %b expected 0", word_valid_o); end
        n_checks++; if (fifo_level_o !== 3'd0) begin n_fail++; $display("FAIL single_end_level: got %0d expected 0", fifo_level_o); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_w [4];
        int          k;
        exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222; exp_w[2] = 32'h33333333; exp_w[3] = 32'h44444444;
        word_ready_i = 1'b0;
        packet_i = {exp_w[3], exp_w[2], exp_w[1], exp_w[0]};
        packet_words_i = 3'd4; packet_valid_i = 1'b1;
        tick();
        packet_valid_i = 1'b0;
        k = 0;
        for (int c = 0; c < 20 && k < 4; c++) begin
            word_ready_i = (c % 2 == 1);
            n_checks++; if (word_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid[c%0d]: got %b expected 1", c, word_valid_o); end
            n_checks++; if (word_o !== exp_w[k]) begin n_fail++; $display("FAIL bp_word[c%0d]: got %h expected %h", c, word_o, exp_w[k]); end
            if (word_ready_i) begin
                n_checks++; if (word_last_o !== (k == 3)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b expected %b", k, word_last_o, (k == 3)); end
                k++;
            end
            tick();
        end
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL bp_handshakes: got %0d expected 4", k); end
        n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_end_valid: got %b expected 0", word_valid_o); end
    endtask

    task automatic test_overflow();
        word_ready_i = 1'b0;
        packet_words_i = 3'd1; packet_valid_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            packet_i = {96'h0, 32'h100 + 32'(i)};
            tick();
        end
        packet_valid_i = 1'b0;
        n_checks++; if (fifo_level_o !== 3'd4) begin n_fail++; $display("FAIL ovf_level: got %0d expected 4", fifo_level_o); end
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow_o); end
        n_checks++; if (drop_cnt_o !== 16'd2) begin n_fail++; $display("FAIL ovf_drop_cnt: got %0d expected 2", drop_cnt_o); end
        word_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (word_o !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL ovf_drain[%0d]: got %h expected %h", i, word_o, 32'h100 + 32'(i)); end
            n_checks++; if (word_last_o !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_last[%0d]: got %b expected 1", i, word_last_o); end
            tick();
        end
        n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL ovf_end_valid: got %b expected 0", word_valid_o); end
        n_checks++; if (fifo_level_o !== 3'd0) begin n_fail++; $display("FAIL ovf_end_level: got %0d expected 0", fifo_level_o); end
        do_flush();
    endtask

    task automatic test_illegal();
        word_ready_i = 1'b1;
        packet_i = {96'h0, 32'hBAD0BAD0};
        packet_valid_i = 1'b1;
        packet_words_i = 3'd0; tick();
        packet_words_i = 3'd5; tick();
        packet_valid_i = 1'b0;
        n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL ill_valid: got %b expected 0", word_valid_o); end
        n_checks++; if (drop_cnt_o !== 16'd2) begin n_fail++; $display("FAIL ill_drop_cnt: got %0d expected 2", drop_cnt_o); end
        n_checks++; if (fifo_level_o !== 3'd0) begin n_fail++; $display("FAIL ill_level: got %0d expected 0", fifo_level_o); end
        packet_i = {64'h0, 32'hBEEF0001, 32'hBEEF0000};
        packet_words_i = 3'd2; packet_valid_i = 1'b1;
        tick();
        packet_valid_i = 1'b0;
        n_checks++; if (word_o !== 32'hBEEF0000 || word_last_o !== 1'b0) begin n_fail++; $display("FAIL ill_next_w0: got %h/%b expected beef0000/0", word_o, word_last_o); end
        tick();
        n_checks++; if (word_o !== 32'hBEEF0001 || word_last_o !== 1'b1) begin n_fail++; $display("FAIL ill_next_w1: got %h/%b expected beef0001/1", word_o, word_last_o); end
        tick();
        n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL ill_end_valid: got %b expected 0", word_valid_o); end
        do_flush();
    endtask

    task automatic test_back_to_back();
        word_ready_i = 1'b1;
        packet_words_i = 3'd2; packet_valid_i = 1'b1;
        packet_i = {64'h0, 32'hA1, 32'hA0}; tick();
        n_checks++; if (word_o !== 32'hA0) begin n_fail++; $display("FAIL b2b_p0w0: got %h expected a0", word_o); end
        packet_i = {64'h0, 32'hB1, 32'hB0}; tick();
        n_checks++; if (word_o !== 32'hA1 || word_last_o !== 1'b1) begin n_fail++; $display("FAIL b2b_p0w1: got %h/%b expected a1/1", word_o, word_last_o); end
        n_checks++; if (fifo_level_o !== 3'd2) begin n_fail++; $display("FAIL b2b_level2: got %0d expected 2", fifo_level_o); end
        packet_i = {64'h0, 32'hC1, 32'hC0}; tick();
        packet_valid_i = 1'b0;
        n_checks++; if (fifo_level_o !== 3'd2) begin n_fail++; $display("FAIL b2b_pushpop_level: got %0d expected 2", fifo_level_o); end
        n_checks++; if (word_valid_o !== 1'b1 || word_o !== 32'hB0) begin n_fail++; $display("FAIL b2b_p1w0: got %h/%b expected b0/1", word_o, word_valid_o); end
        tick();
        n_checks++; if (word_o !== 32'hB1 || word_last_o !== 1'b1) begin n_fail++; $display("FAIL b2b_p1w1: got %h/%b expected b1/1", word_o, word_last_o); end
        tick();
        n_checks++; if (word_valid_o !== 1'b1 || word_o !== 32'hC0) begin n_fail++; $display("FAIL b2b_p2w0: got %h/%b expected c0/1", word_o, word_valid_o); end
        tick(); tick();
        n_checks++; if (word_valid_o !== 1'b0 || fifo_level_o !== 3'd0) begin n_fail++; $display("FAIL b2b_end: got valid %b level %0d expected 0/0", word_valid_o, fifo_level_o); end
    endtask

    task automatic test_disable();
        word_ready_i = 1'b0;
        packet_i = {64'h0, 32'hD1, 32'hD0};
        packet_words_i = 3'd2; packet_valid_i = 1'b1;
        tick();
        enable_i = 1'b0;
        packet_i = {64'h0, 32'hE1, 32'hE0};
        tick(); tick();
        packet_valid_i = 1'b0;
        n_checks++; if (fifo_level_o !== 3'd1 || drop_cnt_o !== 16'd0) begin n_fail++; $display("FAIL dis_ignored: got level %0d drops %0d expected 1/0", fifo_level_o, drop_cnt_o); end
        word_ready_i = 1'b1;
        n_checks++; if (word_o !== 32'hD0) begin n_fail++; $display("FAIL dis_drain_w0: got %h expected d0", word_o); end
        tick();
        n_checks++; if (word_o !== 32'hD1 || word_last_o !== 1'b1) begin n_fail++; $display("FAIL dis_drain_w1: got %h/%b expected d1/1", word_o, word_last_o); end
        tick();
        n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL dis_end_valid: got %b expected 0", word_valid_o); end
        enable_i = 1'b1;
    endtask

    task automatic test_flush();
        word_ready_i = 1'b1;
        packet_words_i = 3'd7; packet_valid_i = 1'b1; tick();
        packet_i = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        packet_words_i = 3'd4; tick();
        packet_valid_i = 1'b0;
        n_checks++; if (drop_cnt_o !== 16'd1 || word_o !== 32'hF0) begin n_fail++; $display("FAIL fl_setup: got drops %0d word %h expected 1/f0", drop_cnt_o, word_o); end
        tick(); tick();
        n_checks++; if (word_o !== 32'hF2) begin n_fail++; $display("FAIL fl_mid: got %h expected f2", word_o); end
        flush_i = 1'b1;
        packet_i = {96'h0, 32'h55}; packet_words_i = 3'd1; packet_valid_i = 1'b1;
        tick();
        flush_i = 1'b0; packet_valid_i = 1'b0;
        n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b expected 0", word_valid_o); end
        n_checks++; if (fifo_level_o !== 3'd0) begin n_fail++; $display("FAIL fl_level: got %0d expected 0", fifo_level_o); end
        n_checks++; if (drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL fl_stats: got drops %0d ovf %b expected 0/0", drop_cnt_o, overflow_o); end
        tick();
        n_checks++; if (word_valid_o !== 1'b0 || fifo_level_o !== 3'd0) begin n_fail++; $display("FAIL fl_no_store: got valid %b level %0d expected 0/0", word_valid_o, fifo_level_o); end
    endtask

    task automatic test_saturation_reset();
        packet_words_i = 3'd0; packet_valid_i = 1'b1;
        for (int i = 0; i < 65534; i++) tick();
        n_checks++; if (drop_cnt_o !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %h expected fffe", drop_cnt_o); end
        for (int i = 0; i < 5; i++) tick();
        packet_valid_i = 1'b0;
        n_checks++; if (drop_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt: got %h expected ffff", drop_cnt_o); end
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b expected 1", overflow_o); end
        word_ready_i = 1'b0;
        packet_i = {32'h4, 32'h3, 32'h2, 32'h1};
        packet_words_i = 3'd4; packet_valid_i = 1'b1; tick();
        packet_valid_i = 1'b0;
        n_checks++; if (word_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_pre_send: got %b expected 1", word_valid_o); end
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        n_checks++; if ({word_valid_o, word_last_o, overflow_o} !== 3'b000 || word_o !== 32'h0 || fifo_level_o !== 3'd0 || drop_cnt_o !== 16'h0)
            begin n_fail++; $display("FAIL rst_mid: got v%b l%b o%b w%h lvl%0d d%h expected all zero", word_valid_o, word_last_o, overflow_o, word_o, fifo_level_o, drop_cnt_o); end
        word_ready_i = 1'b1; tick();
        n_checks++; if (word_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_after: got %b expected 0", word_valid_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_overflow();
        test_illegal();
        test_back_to_back();
        test_disable();
        test_flush();
        test_saturation_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
